// File: rtl/riscv_enc_pkg.sv
// Shared encoding constants, op and FSM state types for the instruction image writer.
// No logic; consumed by the encoder and the writer FSM.
package riscv_enc_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_ADDI = 3'd2,
      OP_XOR  = 3'd3,
      OP_ANDI = 3'd4,
      OP_SRA  = 3'd5,
      OP_LW   = 3'd6,
      OP_SW   = 3'd7
   } op_t;

   localparam logic [6:0] OPCODE_R     = 7'b0110011;
   localparam logic [6:0] OPCODE_I     = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRA  = 3'b101;
   localparam logic [2:0] F3_ANDI = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/instr_encode.sv
// Encodes op + register/immediate fields into a 32-bit RV32I word.
// Latency: purely combinational; backpressure: none (no handshake).
module instr_encode
   import riscv_enc_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] imm,
   output logic [31:0] word
);

   always_comb begin
      word = '0;
      case (op_t'(op))
         OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPCODE_R};
         OP_SUB:  word = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPCODE_R};
         OP_XOR:  word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPCODE_R};
         OP_SRA:  word = {F7_ALT,  rs2, rs1, F3_SRA, rd, OPCODE_R};
         OP_ADDI: word = {imm, rs1, F3_ADD,  rd, OPCODE_I};
         OP_ANDI: word = {imm, rs1, F3_ANDI, rd, OPCODE_I};
         OP_LW:   word = {imm, rs1, F3_WORD, rd, OPCODE_LOAD};
         OP_SW:   word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPCODE_STORE};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/instr_image_writer.sv
// Writes encoded instructions MSB-first as bytes into instruction memory, then a zero terminator on flush.
// Latency: bytes on cycles N+1..N+4 after accept; backpressure: in_ready low while writing, flushing, full or done.
module instr_image_writer
   import riscv_enc_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [11:0]       in_imm,
   input  logic              flush,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              full,
   output logic              done
);

   localparam int WC_W = ADDR_W - 2;
   localparam logic [WC_W-1:0]   WC_MAX = '1;
   localparam logic [WC_W-1:0]   WC_ONE = {{(WC_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] WP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic [31:0]       sreg;
   logic [1:0]        cnt;
   logic [ADDR_W-1:0] wp;
   logic [WC_W-1:0]   word_count;
   logic              flush_pending;
   logic              term;
   logic [31:0]       enc_word;
   logic              accept;

   instr_encode u_enc (
      .op   (in_op),
      .rd   (in_rd),
      .rs1  (in_rs1),
      .rs2  (in_rs2),
      .imm  (in_imm),
      .word (enc_word)
   );

   assign full      = (word_count == WC_MAX);
   assign in_ready  = (state == ST_IDLE) && !full && !flush_pending;
   assign accept    = in_valid && in_ready;
   assign busy      = (state == ST_WRITE);
   assign done      = (state == ST_DONE);
   assign mem_we    = busy;
   assign mem_addr  = wp;
   assign mem_wdata = sreg[31:24];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         sreg          <= '0;
         cnt           <= '0;
         wp            <= '0;
         word_count    <= '0;
         flush_pending <= 1'b0;
         term          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (flush_pending || (flush && !accept)) begin
                  sreg          <= '0;
                  term          <= 1'b1;
                  cnt           <= '0;
                  flush_pending <= 1'b0;
                  state         <= ST_WRITE;
               end else if (accept) begin
                  sreg          <= enc_word;
                  term          <= 1'b0;
                  cnt           <= '0;
                  flush_pending <= flush;
                  state         <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               sreg <= {sreg[23:0], 8'h00};
               cnt  <= cnt + 2'd1;
               if (flush && !term)
                  flush_pending <= 1'b1;
               // Hold wp on the terminator's last byte so it never wraps to 0.
               if (!(term && cnt == 2'd3))
                  wp <= wp + WP_ONE;
               if (cnt == 2'd3) begin
                  if (term) begin
                     state <= ST_DONE;
                  end else begin
                     state      <= ST_IDLE;
                     word_count <= word_count + WC_ONE;
                  end
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/instr_image_writer.md
# instr_image_writer

Builds a RISC-V program image in the byte-wide instruction memory for the fetch/decode stage. It accepts one instruction at a time as decoded fields, encodes it into the 32-bit format for the supported subset (ADD, SUB, ADDI, XOR, ANDI, SRA, LW, SW), and writes it as four bytes, most-significant byte first, so that fetch reassembles the word as {mem[a], mem[a+1], mem[a+2], mem[a+3]}. On flush it appends an all-zero terminator word, which fetch treats as end of program.

## Interface
- ADDR_W, 7, byte-address width; memory depth is 2^ADDR_W bytes (default 128)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept an instruction
- in_op  in  3  0 ADD, 1 SUB, 2 ADDI, 3 XOR, 4 ANDI, 5 SRA, 6 LW, 7 SW
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  12  immediate for ADDI/ANDI/LW/SW
- flush  in  1  one-cycle pulse: write terminator and finish
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte data
- busy  out  1  a word is being written
- full  out  1  no room for another instruction (terminator slot reserved)
- done  out  1  terminator written; sticky until rst

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: in_ready = !full. When in_valid && in_ready, the encoded word is latched into a 32-bit shift register, byte counter = 0, and the state moves to WRITE.
- WRITE: mem_we = 1, mem_wdata = sreg[31:24], mem_addr = wp. Each cycle sreg shifts left by 8 and wp increments. After the 4th byte: if a terminator is being written, go to DONE, otherwise go to IDLE and increment word_count.
- Encoding; fields not used by an op are ignored:
  - ADD/SUB/XOR/SRA: {f7, rs2, rs1, f3, rd, 0110011}, with f7/f3 = ADD 0000000/000, SUB 0100000/000, XOR 0000000/100, SRA 0100000/101.
  - ADDI/ANDI: {imm, rs1, f3, rd, 0010011}, with f3 = 000 and 111.
  - LW: {imm, rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
- Flush:
  - Flush in IDLE with no accept that cycle: load sreg = 0 and enter WRITE as terminator.
  - Flush in the same cycle as an accept, or during WRITE: set flush_pending. The terminator starts from IDLE the cycle after the current word completes; in_ready = 0 while flush_pending.
  - Flush in DONE: ignored.
- full = (word_count == 2^ADDR_W/4 − 1), i.e. 31 by default. When full, in_ready = 0; flush is still honoured.
- DONE: in_ready = 0, busy = 0, mem_we = 0, done = 1.
- Reset in any state:
  - state = IDLE, wp = 0, word_count = 0, flush_pending = 0, sreg = 0.
  - A partial word is abandoned with no further writes.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, busy 0, full 0, done 0, in_ready 1.
- Accept sampled at edge N; bytes appear on cycles N+1..N+4 at wp..wp+3; in_ready = 1 again on cycle N+5. Throughput is 1 instruction per 5 cycles.
- mem_* outputs are driven from registers only, with no combinational path from in_*.
- busy = (state == WRITE).
- full and done update on the edge that completes the relevant word.
- wp never wraps: the full limit guarantees the terminator fits at bytes 2^ADDR_W−4..2^ADDR_W−1.

## Structure
- Package riscv_enc_pkg contains:
  - the op enum (3-bit)
  - OPCODE_R/OPCODE_I/OPCODE_LOAD/OPCODE_STORE constants
  - funct3/funct7 constants
  - state enum
- Sub-module instr_encode: purely combinational op+fields → 32-bit word, reusable by the testbench as a reference model.
- The top level holds the FSM, shift register, and counters.

## Test plan
- ADD rd=3 rs1=1 rs2=2 after reset → bytes 00,20,81,B3 at addresses 0..3 on four consecutive cycles; in_ready low for those four cycles.
- SUB rd=5 rs1=6 rs2=7, then ADDI rd=1 rs1=0 imm=FFF → 40,73,02,B3 at 0..3, then FF,F0,00,93 at 4..7.
- SW rs1=1 rs2=2 imm=008, then flush → 00,20,A4,23 at 0..3, then 00,00,00,00 at 4..7; done rises after address 7; in_valid then ignored.
- Flush in the same cycle as an LW accept (rd=4 rs1=2 imm=010) → 01,01,22,03 at 0..3, then terminator at 4..7, with no gap beyond one IDLE cycle.
- Write 31 instructions → full = 1 and in_ready = 0 at wp = 124; flush writes zeros at 124..127; done = 1.
- Assert rst after the 2nd byte of a word → no writes on the next cycle; mem_addr = 0; in_ready = 1; the next instruction is written at address 0.
